// File: rtl/inv_shift_sub_if.sv
// Valid/ready bus for the InvShiftRows + InvSubBytes stage: state in, result out.
interface inv_shift_sub_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/inv_shift_sub.sv
// AES decryption InvShiftRows + InvSubBytes, one state column per cycle through
// four inverse S-box lanes; includes the combinational inverse_sbox lookup.
module inverse_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // Entry x lives at bits [2047-8x -: 8], so its base offset is 8*(255-x).
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    assign dout = INV_SBOX[{~din, 3'b000} +: 8];
endmodule

module inv_shift_sub (
    input  logic               clk,
    input  logic               rst_n,
    inv_shift_sub_if.slave     bus,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] src_q, src_d;
    logic [127:0] out_q, out_d;
    logic [7:0]   lane_in  [4];
    logic [7:0]   lane_out [4];

    // Byte i = 4*col + row sits at bits [127-8i -: 8].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                res[8*(15 - (4*c + r)) +: 8] = s[8*(15 - (4*((c + 4 - r) % 4) + r)) +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int unsigned r = 0; r < 4; r++) begin
            lane_in[r] = src_q[8*(15 - (4*int'(col_q) + r)) +: 8];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        inverse_sbox u_sbox (
            .din  (lane_in[g]),
            .dout (lane_out[g])
        );
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        src_d   = src_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = BUSY;
                    src_d   = inv_shift_rows(bus.in_state);
                    col_d   = '0;
                end
            end
            BUSY: begin
                for (int unsigned r = 0; r < 4; r++) begin
                    out_d[8*(15 - (4*int'(col_q) + r)) +: 8] = lane_out[r];
                end
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            src_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            src_q   <= src_d;
            out_q   <= out_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_state = out_q;
    assign busy          = (state_q == BUSY);
endmodule
